// File: rtl/sccb_pkg.sv
// sccb_pkg: shared types and constants for the SCCB 3-phase write driver.
//   sccb_state_t    - driver FSM states
//   SCCB_BITS       - bits per write frame (4 phases x 9 bits)
//   SCCB_QTRS       - quarters per SIO_C period
//   SCCB_TOTAL_QTRS - quarters per frame (START + 36 bits + STOP)
//   SCCB_ACK_BITx   - frame bit indices of the 9th (don't-care) bit of each phase
//   OV5640_WR_ID    - OV5640 8-bit write ID
package sccb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StShift,
    StStop
  } sccb_state_t;

  localparam int unsigned SCCB_BITS       = 36;
  localparam int unsigned SCCB_QTRS       = 4;
  localparam int unsigned SCCB_TOTAL_QTRS = 152;

  localparam logic [5:0] SCCB_ACK_BIT0 = 6'd8;
  localparam logic [5:0] SCCB_ACK_BIT1 = 6'd17;
  localparam logic [5:0] SCCB_ACK_BIT2 = 6'd26;
  localparam logic [5:0] SCCB_ACK_BIT3 = 6'd35;

  localparam logic [7:0] OV5640_WR_ID = 8'h78;

  function automatic logic is_ack_bit(logic [5:0] b);
    return (b == SCCB_ACK_BIT0) || (b == SCCB_ACK_BIT1) ||
           (b == SCCB_ACK_BIT2) || (b == SCCB_ACK_BIT3);
  endfunction

endpackage

// File: rtl/sccb_qtr_tick.sv
// sccb_qtr_tick: quarter-period timer for the SCCB driver.
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - count enable; when low the counter and quarter index are cleared
//   tick       - high in the last system clock of each quarter
//   qtr        - current quarter index 0..3 within the SIO_C period
module sccb_qtr_tick
  import sccb_pkg::*;
#(
  parameter int unsigned QTR_CNT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       tick,
  output logic [1:0] qtr
);

  localparam int unsigned CntW = (QTR_CNT > 1) ? $clog2(QTR_CNT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(QTR_CNT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      qtr_q, qtr_d;

  assign tick = en && (cnt_q == CntLast);
  assign qtr  = qtr_q;

  always_comb begin
    cnt_d = cnt_q;
    qtr_d = qtr_q;
    if (!en) begin
      cnt_d = '0;
      qtr_d = '0;
    end else if (tick) begin
      cnt_d = '0;
      qtr_d = qtr_q + 2'd1;  // wraps 3 -> 0 at the end of each bit period
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      qtr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      qtr_q <= qtr_d;
    end
  end

endmodule

// File: rtl/sccb_wr_driver.sv
// sccb_wr_driver: SCCB 3-phase write master (device ID, addr hi, addr lo, data).
//   clk, rst_n   - clock, asynchronous active-low reset
//   trig         - write request, accepted only while idle
//   driver_addr  - 16-bit register address, captured on accepted trig
//   driver_data  - 8-bit register value, captured on accepted trig
//   driver_end   - one-cycle pulse when the frame (incl. STOP) is complete
//   busy         - high from accepted trig until driver_end
//   sio_c        - SCCB clock pin (registered)
//   sio_d_out    - SCCB data value (registered)
//   sio_d_oe     - SCCB data enable, 0 releases the pad (registered)
//   sio_d_in     - SCCB data pad input
//   ack_err      - NACK seen on a 9th bit during the last frame
// Optional feature macro: SCCB_ACK_CHK_EN enables 9th-bit sampling into ack_err;
// without it sio_d_in is ignored and ack_err is tied low.
module sccb_wr_driver
  import sccb_pkg::*;
#(
  parameter int unsigned QTR_CNT = 32,
  parameter logic [7:0]  DEV_ID  = OV5640_WR_ID
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig,
  input  logic [15:0] driver_addr,
  input  logic [7:0]  driver_data,
  output logic        driver_end,
  output logic        busy,
  output logic        sio_c,
  output logic        sio_d_out,
  output logic        sio_d_oe,
  input  logic        sio_d_in,
  output logic        ack_err
);

  localparam logic [5:0] LastBit = 6'(SCCB_BITS - 1);

  sccb_state_t state_q, state_d;
  logic [5:0]  bit_q, bit_d;
  logic [35:0] word_q, word_d;
  logic        busy_q, busy_d;
  logic        end_q, end_d;
  logic        c_q, c_d, d_q, d_d, oe_q, oe_d;

  logic        qtr_en, tick, qtr_last;
  logic [1:0]  qtr, qtr_nxt;

  assign qtr_en   = (state_q != StIdle);
  assign qtr_last = tick && (qtr == 2'd3);

  sccb_qtr_tick #(
    .QTR_CNT(QTR_CNT)
  ) u_qtr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (qtr_en),
    .tick (tick),
    .qtr  (qtr)
  );

  // Frame sequencing; word_q shifts left so word_q[35] is always the current bit.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    word_d  = word_q;
    busy_d  = busy_q;
    end_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trig) begin
          state_d = StStart;
          bit_d   = '0;
          word_d  = {DEV_ID, 1'b1, driver_addr[15:8], 1'b1,
                     driver_addr[7:0], 1'b1, driver_data, 1'b1};
          busy_d  = 1'b1;
        end
      end
      StStart: begin
        if (qtr_last) state_d = StShift;
      end
      StShift: begin
        if (qtr_last) begin
          if (bit_q == LastBit) begin
            state_d = StStop;
          end else begin
            bit_d  = bit_q + 6'd1;
            word_d = {word_q[34:0], 1'b0};
          end
        end
      end
      StStop: begin
        if (qtr_last) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          end_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Quarter index that will be current next cycle; lets the pin registers
  // present each quarter's levels in its first cycle.
  always_comb begin
    qtr_nxt = qtr;
    if (state_d == StIdle) begin
      qtr_nxt = 2'd0;
    end else if (tick) begin
      qtr_nxt = qtr + 2'd1;
    end
  end

  // Pin levels for the next cycle, decoded from next state/quarter/bit.
  always_comb begin
    c_d  = 1'b1;
    d_d  = 1'b1;
    oe_d = 1'b1;
    unique case (state_d)
      StIdle: ;
      StStart: begin
        c_d = (qtr_nxt != 2'd3);
        d_d = (qtr_nxt == 2'd0);
      end
      StShift: begin
        c_d = (qtr_nxt == 2'd1) || (qtr_nxt == 2'd2);
        if (is_ack_bit(bit_d)) begin
          oe_d = 1'b0;
        end else begin
          d_d = word_d[35];
        end
      end
      StStop: begin
        c_d = (qtr_nxt != 2'd0);
        d_d = (qtr_nxt >= 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bit_q   <= '0;
      word_q  <= '0;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
      c_q     <= 1'b1;
      d_q     <= 1'b1;
      oe_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      busy_q  <= busy_d;
      end_q   <= end_d;
      c_q     <= c_d;
      d_q     <= d_d;
      oe_q    <= oe_d;
    end
  end

  assign driver_end = end_q;
  assign busy       = busy_q;
  assign sio_c      = c_q;
  assign sio_d_out  = d_q;
  assign sio_d_oe   = oe_q;

`ifdef SCCB_ACK_CHK_EN
  logic ack_q, ack_d;
  logic ack_sample;

  // One sample per 9th bit, taken in the last cycle of its high SIO_C quarter.
  assign ack_sample = (state_q == StShift) && tick && (qtr == 2'd2) && is_ack_bit(bit_q);

  always_comb begin
    ack_d = ack_q;
    if ((state_q == StIdle) && trig) begin
      ack_d = 1'b0;
    end else if (ack_sample && sio_d_in) begin
      ack_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
    end
  end

  assign ack_err = ack_q;
`else
  logic unused_sio_d_in;
  assign unused_sio_d_in = sio_d_in;
  assign ack_err         = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_wr_driver.sv
// tb_sccb_wr_driver: directed self-checking bench for sccb_wr_driver (QTR_CNT = 4).
// A passive bus decoder watches SIO_C/SIO_D (released line reads as pulled-up 1)
// and records START/STOP events and the 8-bit bytes of each 9-bit group.
module tb_sccb_wr_driver;

  localparam int unsigned QTR = 4;
  localparam int EndOff  = 152 * QTR + 1;  // 609
  localparam int BusyLen = 152 * QTR;      // 608
`ifdef SCCB_ACK_CHK_EN
  localparam int ExpNack = 1;
`else
  localparam int ExpNack = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic [15:0] driver_addr = '0;
  logic [7:0]  driver_data = '0;
  logic        sio_d_in = 1'b0;
  logic        driver_end, busy, sio_c, sio_d_out, sio_d_oe, ack_err;

  always #5 clk = ~clk;

  sccb_wr_driver #(
    .QTR_CNT(QTR),
    .DEV_ID (8'h78)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trig       (trig),
    .driver_addr(driver_addr),
    .driver_data(driver_data),
    .driver_end (driver_end),
    .busy       (busy),
    .sio_c      (sio_c),
    .sio_d_out  (sio_d_out),
    .sio_d_oe   (sio_d_oe),
    .sio_d_in   (sio_d_in),
    .ack_err    (ack_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_end   = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (driver_end) n_end <= n_end + 1;
  end

  // Bus decoder
  logic       pc = 1'b1, pd = 1'b1, ld;
  int         nbit = 0;
  logic [8:0] sh = '0;
  logic [7:0] bytes[$];
  int         n_start = 0, n_stop = 0, n_oe0 = 0, n_ack_oe0 = 0;

  always @(negedge clk) begin
    ld = sio_d_oe ? sio_d_out : 1'b1;
    if (!sio_d_oe) n_oe0++;
    if (pc && sio_c && pd && !ld) begin
      n_start++;
      nbit = 0;
    end else if (pc && sio_c && !pd && ld) begin
      n_stop++;
    end
    if (!pc && sio_c) begin
      sh = {sh[7:0], ld};
      nbit++;
      if (nbit == 9) begin
        bytes.push_back(sh[8:1]);
        if (!sio_d_oe) n_ack_oe0++;
        nbit = 0;
      end
    end
    pc = sio_c;
    pd = ld;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one write from the current cycle and run until driver_end (bounded).
  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int glitch_at,
                          input bit nack, output int end_off, output int busy_cnt,
                          output int first_busy, output int first_ack);
    int t0;
    int off;
    t0          = cyc;
    trig        = 1'b1;
    driver_addr = a;
    driver_data = d;
    end_off     = -1;
    busy_cnt    = 0;
    first_busy  = -1;
    first_ack   = -1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      trig = 1'b0;
      off  = cyc - t0;
      if (off == 1) begin
        first_busy = int'(busy);
        first_ack  = int'(ack_err);
      end
      if (off == glitch_at) begin
        trig        = 1'b1;
        driver_addr = 16'hFFFF;
        driver_data = 8'hFF;
      end
      // NACK across the 9th bit of phase 2 (frame bit 17: offsets 289..304)
      sio_d_in = nack && (off >= 290) && (off <= 303);
      if (busy) busy_cnt++;
      if (driver_end) begin
        end_off = off;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int q0, input int st0, input int sp0,
                             input logic [31:0] exp);
    check_eq({tag, "_starts"}, n_start - st0, 1);
    check_eq({tag, "_stops"}, n_stop - sp0, 1);
    check_eq({tag, "_nbytes"}, bytes.size() - q0, 4);
    for (int i = 0; i < 4; i++) begin
      if (bytes.size() > q0 + i)
        check_eq($sformatf("%s_byte%0d", tag, i), int'(bytes[q0+i]), int'(exp[31-8*i -: 8]));
      else
        check_eq($sformatf("%s_byte%0d", tag, i), -1, int'(exp[31-8*i -: 8]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int eo, bc, fb, fa, q0, st0, sp0, e0, oe0, ao0, t0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_sio_c", int'(sio_c), 1);
    check_eq("rst_sio_d_out", int'(sio_d_out), 1);
    check_eq("rst_sio_d_oe", int'(sio_d_oe), 1);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_driver_end", int'(driver_end), 0);
    check_eq("rst_ack_err", int'(ack_err), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic write 0x3008 <- 0x82
    q0 = bytes.size(); st0 = n_start; sp0 = n_stop; e0 = n_end;
    do_write(16'h3008, 8'h82, -1, 1'b0, eo, bc, fb, fa);
    check_eq("w1_end_off", eo, EndOff);
    check_eq("w1_busy_cycles", bc, BusyLen);
    check_eq("w1_busy_at_start", fb, 1);
    check_eq("w1_busy_at_end", int'(busy), 0);
    check_eq("w1_ack_err", int'(ack_err), 0);
    check_frame("w1", q0, st0, sp0, 32'h7830_0882);

    // Back-to-back: trig in the driver_end cycle
    q0 = bytes.size(); st0 = n_start; sp0 = n_stop;
    do_write(16'h3103, 8'h02, -1, 1'b0, eo, bc, fb, fa);
    check_eq("w2_busy_next_cycle", fb, 1);
    check_eq("w2_end_off", eo, EndOff);
    check_frame("w2", q0, st0, sp0, 32'h7831_0302);
    repeat (5) @(posedge clk);
    #1;
    check_eq("w12_end_pulses", n_end - e0, 2);

    // trig mid-SHIFT is ignored
    q0 = bytes.size(); st0 = n_start; sp0 = n_stop; e0 = n_end;
    do_write(16'h4300, 8'h30, 200, 1'b0, eo, bc, fb, fa);
    check_eq("w3_end_off", eo, EndOff);
    repeat (40) @(posedge clk);
    #1;
    check_eq("w3_end_pulses", n_end - e0, 1);
    check_eq("w3_busy_after", int'(busy), 0);
    check_frame("w3", q0, st0, sp0, 32'h7843_0030);

    // Protocol: 9th bits released for all four quarters
    q0 = bytes.size(); st0 = n_start; sp0 = n_stop; oe0 = n_oe0; ao0 = n_ack_oe0;
    do_write(16'h5800, 8'h23, -1, 1'b0, eo, bc, fb, fa);
    check_eq("w4_oe0_cycles", n_oe0 - oe0, 4 * 4 * QTR);
    check_eq("w4_oe0_at_9th_rise", n_ack_oe0 - ao0, 4);
    check_frame("w4", q0, st0, sp0, 32'h7858_0023);

    // NACK on phase 2, then cleared by the next accepted trig
    repeat (3) @(posedge clk);
    #1;
    do_write(16'h3008, 8'h82, -1, 1'b1, eo, bc, fb, fa);
    check_eq("w5_end_off", eo, EndOff);
    check_eq("w5_ack_err", int'(ack_err), ExpNack);
    do_write(16'h3008, 8'h82, -1, 1'b0, eo, bc, fb, fa);
    check_eq("w6_ack_cleared", fa, 0);
    check_eq("w6_ack_err_end", int'(ack_err), 0);

    // Reset during bit 20
    repeat (3) @(posedge clk);
    #1;
    e0          = n_end;
    t0          = cyc;
    trig        = 1'b1;
    driver_addr = 16'h3008;
    driver_data = 8'h82;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      trig = 1'b0;
      if (cyc - t0 == 345) break;
    end
    check_eq("rm_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_eq("rm_sio_c", int'(sio_c), 1);
    check_eq("rm_sio_d_out", int'(sio_d_out), 1);
    check_eq("rm_sio_d_oe", int'(sio_d_oe), 1);
    check_eq("rm_busy", int'(busy), 0);
    check_eq("rm_driver_end", int'(driver_end), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (700) @(posedge clk);
    #1;
    check_eq("rm_no_end", n_end - e0, 0);
    check_eq("rm_busy_after", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
